// File: rtl/cpu6_immenc.sv
`default_nettype none
// ============================================================================
// Module      : cpu6_immenc
// Description : Immediate encoder / instruction assembler for cpu6. Scatters
//               a sign-extended immediate (I/S/B) into an instruction
//               template. Encoded words are queued in a small output FIFO
//               with valid/ready handshakes on both sides.
//               Optional build macro CPU6_IMMENC_RANGECHK_EN enables
//               immediate range checking and the saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_BRANCHTYPE_SIZE
`define CPU6_BRANCHTYPE_SIZE 3
`endif
`ifndef CPU6_IMMTYPE_I
`define CPU6_IMMTYPE_I 3'd1
`endif
`ifndef CPU6_IMMTYPE_S
`define CPU6_IMMTYPE_S 3'd2
`endif
`ifndef CPU6_IMMTYPE_B
`define CPU6_IMMTYPE_B 3'd3
`endif

module cpu6_immenc #(
    parameter int DEPTH    = 2,
    parameter int ERRCNT_W = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [`CPU6_XLEN-1:0]            in_base,
    input  logic [`CPU6_BRANCHTYPE_SIZE-1:0] in_immtype,
    input  logic [`CPU6_XLEN-1:0]            in_imm,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [`CPU6_XLEN-1:0]            out_instr,
    output logic                             out_err,
    output logic [ERRCNT_W-1:0]              err_cnt
);

    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [`CPU6_XLEN-1:0] w_instr;
    logic                  w_err;
    logic                  w_push;
    logic                  w_pop;

    logic [`CPU6_XLEN-1:0] r_mem_instr [DEPTH];
    logic                  r_mem_err   [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;

    // Scatter the immediate into the template; covered bits are overwritten
    always_comb begin
        w_instr = in_base;
        case (in_immtype)
            `CPU6_IMMTYPE_I: begin
                w_instr[31:20] = in_imm[11:0];
            end
            `CPU6_IMMTYPE_S: begin
                w_instr[31:25] = in_imm[11:5];
                w_instr[11:7]  = in_imm[4:0];
            end
            `CPU6_IMMTYPE_B: begin
                w_instr[31]    = in_imm[12];
                w_instr[7]     = in_imm[11];
                w_instr[30:25] = in_imm[10:5];
                w_instr[11:8]  = in_imm[4:1];
            end
            default: begin
                w_instr = in_base;
            end
        endcase
    end

`ifdef CPU6_IMMENC_RANGECHK_EN
    logic [ERRCNT_W-1:0] r_err_cnt;

    // Flag immediates that do not fit the selected field (B also needs even)
    always_comb begin
        w_err = 1'b0;
        case (in_immtype)
            `CPU6_IMMTYPE_I, `CPU6_IMMTYPE_S: begin
                w_err = !((&in_imm[`CPU6_XLEN-1:11]) | ~(|in_imm[`CPU6_XLEN-1:11]));
            end
            `CPU6_IMMTYPE_B: begin
                w_err = !((&in_imm[`CPU6_XLEN-1:12]) | ~(|in_imm[`CPU6_XLEN-1:12]))
                        | in_imm[0];
            end
            default: begin
                w_err = 1'b0;
            end
        endcase
    end

    // Saturating count of accepted requests carrying a range error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err && (r_err_cnt != {ERRCNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    // Upper immediate bits only matter to the range checker
    logic w_unused_imm;
    assign w_unused_imm = ^in_imm[`CPU6_XLEN-1:13];

    assign w_err   = 1'b0;
    assign err_cnt = '0;
`endif

    assign in_ready  = (r_count != c_depth);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_instr = r_mem_instr[r_rd_ptr];
    assign out_err   = r_mem_err[r_rd_ptr];

    // FIFO storage, pointers and occupancy; reset clears storage so the head reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_err[i]   <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_instr;
                r_mem_err[r_wr_ptr]   <= w_err;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/cpu6_immenc.md
Name: cpu6_immenc

Overview:
- Immediate encoder and instruction assembler for cpu6. It is the inverse of the immediate decode path.
- Takes an instruction template and a sign-extended XLEN immediate with its immtype (I/S/B), and scatters the immediate bits into the RISC-V instruction fields.
- Encoded words queue in a small output FIFO with valid/ready handshakes on both sides.
- Used by the debug/boot instruction-injection path and by self-check benches to generate instruction words.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2).
- ERRCNT_W, 16, width of the saturating range-error counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_base  input  `CPU6_XLEN  instruction template (opcode/rd/rs1/rs2/funct bits)
- in_immtype  input  `CPU6_BRANCHTYPE_SIZE  `CPU6_IMMTYPE_I / _S / _B; any other code means no immediate
- in_imm  input  `CPU6_XLEN  sign-extended immediate
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_instr  output  `CPU6_XLEN  encoded instruction at FIFO head
- out_err  output  1  head entry had an out-of-range immediate
- err_cnt  output  ERRCNT_W  saturating count of accepted requests with error

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values:
  - FIFO pointers and count = 0.
  - out_valid = 0, out_err = 0, err_cnt = 0.
  - out_instr = 0 (head storage cleared).
  - in_ready = 1 in the first cycle after reset deasserts.
- Encoding is combinational on the inputs. Bits not covered by the immediate field are copied from in_base. Bits covered by the field are overwritten, never ORed.
  - I: instr[31:20] = imm[11:0].
  - S: instr[31:25] = imm[11:5]; instr[11:7] = imm[4:0].
  - B: instr[31] = imm[12]; instr[7] = imm[11]; instr[30:25] = imm[10:5]; instr[11:8] = imm[4:1]; imm[0] is dropped.
  - Other immtype: instr = in_base unchanged, err = 0.
- Push and pop:
  - Push on in_valid & in_ready: the encoded word plus its err bit are written at the write pointer.
  - Pop on out_valid & out_ready.
- Latency: a push at edge N into an empty FIFO gives out_valid = 1 with that word after edge N. No combinational input-to-output path.
- in_ready = (count != DEPTH). It is registered-derived only and does not depend on out_ready in the same cycle (no full-bypass).
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Pop when empty: ignored (out_valid = 0).
- Wrap-around: pointers wrap modulo DEPTH.
- Stability: while out_valid & !out_ready, out_instr and out_err hold stable.
- err_cnt increments by 1 on each push with err = 1 and saturates at all-ones.
- Reset mid-operation: all queued entries are discarded. Any request presented in the reset cycle is not accepted.

Optional Feature:
- Macro: CPU6_IMMENC_RANGECHK_EN.
- Defined:
  - err = 1 for type I or S when in_imm is not representable as signed 12-bit (bits [XLEN-1:11] not all equal).
  - err = 1 for type B when in_imm is not representable as signed 13-bit, or when imm[0] = 1.
  - The word is still encoded from the truncated bits.
- Undefined:
  - No range logic. err is forced to 0, out_err = 0, and err_cnt stays 0 (err_cnt port kept, tied to constant).

Test Plan:
- I-type: base 0x00000093, imm 0xFFFFFFFF, type I, out_ready = 1 -> out_instr = 0xFFF00093 one cycle after accept, out_err = 0.
- S-type: base 0x0020A023, imm 0x00000008 -> 0x0020A423. Template bits under the field set to 1 (base 0xFE20AFA3), same imm -> 0x0020A423 (overwrite verified).
- B-type: base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3.
- Range, with CPU6_IMMENC_RANGECHK_EN:
  - I imm 0x00000800, base 0x93 -> out_instr 0x80000093, out_err = 1, err_cnt 0->1.
  - B imm 0x00000003 -> out_err = 1, err_cnt = 2.
  - Without the macro: same inputs -> out_err = 0, err_cnt = 0.
- Backpressure (DEPTH = 2): hold out_ready = 0 and present 3 requests -> in_ready drops after the 2nd accept, 3rd held, head stable. Release out_ready -> words drain in order, 3rd accepted on the first pop cycle+1.
- Reset: with 2 entries queued and err_cnt = 5, assert reset 1 cycle -> out_valid = 0, err_cnt = 0, in_ready = 1 next cycle, old entries never appear.
